mem_stage_dmem_ctrl: RTL
========================

// Module: mem_stage_dmem_ctrl
// PURPOSE
//  MEM-stage data-memory controller between the EX/MEM and MEM/WB pipeline registers.
//  Turns the EX/MEM load/store into a data-cache request, holds it until dcache_resp, and stalls the pipe meanwhile.
//  Hands the word-aligned address and raw read word to MEM/WB; writeback does the byte/half extraction.
// PARAMETERS
//  width      32  address/data width; only 32 is supported
//  CNT_WIDTH  32  perf-counter width; used only with DMEM_PERF_CNT_EN
// PORTS
//  clk               in   1      clock, all state on posedge
//  rst               in   1      reset, synchronous, active-low
//  ex_mem_valid      in   1      EX/MEM holds a real instruction (0 = bubble)
//  ex_mem_is_load    in   1      instruction is a load
//  ex_mem_is_store   in   1      instruction is a store
//  ex_mem_funct3     in   3      000 B, 001 H, 010 W, 100 BU, 101 HU
//  ex_mem_alu_out    in   width  effective byte address
//  ex_mem_rs2_out    in   width  store data
//  pipe_advance      in   1      global pipe-register load strobe, already ANDed with !dmem_stall
//  dcache_resp       in   1      cache done with current request
//  dcache_rdata      in   width  cache read word, valid with dcache_resp
//  dcache_read       out  1      read request
//  dcache_write      out  1      write request
//  dcache_address    out  width  {ex_mem_alu_out[31:2],2'b00}
//  dcache_wdata      out  width  ex_mem_rs2_out << (8*alu_out[1:0])
//  dcache_mbe        out  4      byte enables
//  dmem_stall        out  1      MEM stage not ready; freezes all pipe registers
//  datacache_address out  width  to MEM/WB; same as dcache_address
//  data_cache_rdata  out  width  to MEM/WB; raw read word
//  misaligned        out  1      current access is misaligned and was suppressed
// BEHAVIOUR
//  access = ex_mem_valid & (is_load|is_store) & !misaligned.
//  misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. Misaligned access: no request, no stall, flag held while in EX/MEM.
//  dcache_mbe: loads 4'b1111. SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111. Forced 0 when no request.
//  FSM states:
//    IDLE  read/write = access & load/store, driven combinationally (0-cycle issue).
//          access & !resp -> BUSY. access & resp & !pipe_advance -> DONE. Otherwise stay IDLE.
//    BUSY  request held stable (addr/data/mbe/rd/wr) until resp. resp & pipe_advance -> IDLE. resp & !pipe_advance -> DONE.
//    DONE  request deasserted; never re-issued. pipe_advance -> IDLE.
//  On resp for a load, dcache_rdata is captured into rdata_q.
//  dmem_stall = access & !resp in IDLE/BUSY; 0 in DONE. It is combinational, and resp drops it in the same cycle.
//  data_cache_rdata = dcache_rdata when resp; else rdata_q. Stores leave rdata_q unchanged.
//  Latency: a cache hit with same-cycle resp costs 0 stall cycles. Otherwise stall cycles = cycles until resp.
//  Simultaneous resp + other-stage stall: the access completes exactly once (DONE) and its data is held for MEM/WB.
//  Bubble/non-memory instruction: no request, no stall, state stays IDLE.
//  Reset (rst=0), including mid-request: state IDLE, rdata_q=0, counters=0.
//    All outputs are 0 during reset; dcache_read/write are forced low.
//    The cache must drop an abandoned request.
// CONFIGURATION
//  DMEM_PERF_CNT_EN defined:
//    Adds outputs perf_loads, perf_stores, perf_stall_cycles (CNT_WIDTH each).
//    perf_loads/perf_stores increment once per completed access (at resp).
//    perf_stall_cycles increments each cycle dmem_stall=1.
//    Counters saturate at all-ones and reset to 0.
//  DMEM_PERF_CNT_EN undefined: ports and counters absent; behaviour is otherwise identical.
// TESTING
//  1. LW 0x1000, resp in same cycle, pipe_advance=1 -> dcache_read 1 cycle, dmem_stall=0, data_cache_rdata=dcache_rdata.
//  2. SB rs2=0x000000AB to 0x1003, resp after 3 cycles -> mbe=4'b1000, wdata=0xAB000000, addr=0x1000,
//     dmem_stall=1 for 3 cycles, request stable throughout.
//  3. LW, resp together with pipe_advance=0 for 2 cycles -> DONE, no re-issue, data_cache_rdata held at resp value, IDLE after advance.
//  4. LH to 0x2001 -> dcache_read=0, misaligned=1, dmem_stall=0. SW to 0x2002 -> same result.
//  5. rst=0 during BUSY -> next cycle dcache_read/write=0, state IDLE, data_cache_rdata=0.
//  6. With DMEM_PERF_CNT_EN: 2 loads (1 stall cycle each) + 1 store (0 stall cycles)
//     -> perf_loads=2, perf_stores=1, perf_stall_cycles=2.

Source files
------------

// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: issues EX/MEM loads/stores to the data cache and stalls the pipe until dcache_resp.
// Optional perf counters (perf_loads, perf_stores, perf_stall_cycles) are built only when DMEM_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | no outstanding request; a new access issues combinationally
// BUSY  | request outstanding, held until dcache_resp
// DONE  | access completed, waiting for pipe_advance; no re-issue
module mem_stage_dmem_ctrl #(
  parameter int width     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_mem_valid,
  input  logic                 ex_mem_is_load,
  input  logic                 ex_mem_is_store,
  input  logic [2:0]           ex_mem_funct3,
  input  logic [width-1:0]     ex_mem_alu_out,
  input  logic [width-1:0]     ex_mem_rs2_out,
  input  logic                 pipe_advance,
  input  logic                 dcache_resp,
  input  logic [width-1:0]     dcache_rdata,
  output logic                 dcache_read,
  output logic                 dcache_write,
  output logic [width-1:0]     dcache_address,
  output logic [width-1:0]     dcache_wdata,
  output logic [3:0]           dcache_mbe,
  output logic                 dmem_stall,
  output logic [width-1:0]     datacache_address,
  output logic [width-1:0]     data_cache_rdata,
  output logic                 misaligned
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_loads,
  output logic [CNT_WIDTH-1:0] perf_stores,
  output logic [CNT_WIDTH-1:0] perf_stall_cycles
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [width-1:0] rdata_q;
  logic [1:0]       byte_off;
  logic             is_mem;
  logic             misalign_cond;
  logic             access;
  logic             req_active;
  logic [3:0]       mbe_raw;

  assign byte_off = ex_mem_alu_out[1:0];
  assign is_mem   = ex_mem_valid & (ex_mem_is_load | ex_mem_is_store);

  always_comb begin
    misalign_cond = 1'b0;
    case (ex_mem_funct3)
      3'b001, 3'b101: misalign_cond = byte_off[0];
      3'b010:         misalign_cond = (byte_off != 2'b00);
      default:        misalign_cond = 1'b0;
    endcase
  end

  assign access = is_mem & ~misalign_cond;
  // DONE suppresses the request so a completed access is never sent twice.
  assign req_active = access & (state_q != DONE);

  always_comb begin
    mbe_raw = 4'b1111;
    if (!ex_mem_is_load) begin
      case (ex_mem_funct3[1:0])
        2'b00:   mbe_raw = 4'b0001 << byte_off;
        2'b01:   mbe_raw = 4'b0011 << byte_off;
        default: mbe_raw = 4'b1111;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (access && !dcache_resp)
          state_d = BUSY;
        else if (access && dcache_resp && !pipe_advance)
          state_d = DONE;
      end
      BUSY: begin
        if (!access)
          state_d = IDLE;
        else if (dcache_resp)
          state_d = pipe_advance ? IDLE : DONE;
      end
      DONE: begin
        if (pipe_advance)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_active && dcache_resp && ex_mem_is_load)
        rdata_q <= dcache_rdata;
    end
  end

  // Every output is gated by reset so an abandoned request drops immediately.
  assign dcache_read       = rst & req_active & ex_mem_is_load;
  assign dcache_write      = rst & req_active & ex_mem_is_store;
  assign dcache_mbe        = (rst && req_active) ? mbe_raw : 4'b0000;
  assign dcache_address    = rst ? {ex_mem_alu_out[width-1:2], 2'b00} : '0;
  assign datacache_address = dcache_address;
  assign dcache_wdata      = rst ? (ex_mem_rs2_out << {byte_off, 3'b000}) : '0;
  assign dmem_stall        = rst & req_active & ~dcache_resp;
  assign data_cache_rdata  = !rst ? '0 : (dcache_resp ? dcache_rdata : rdata_q);
  assign misaligned        = rst & is_mem & misalign_cond;

`ifdef DMEM_PERF_CNT_EN
  logic done_load, done_store;

  assign done_load  = req_active & dcache_resp & ex_mem_is_load;
  assign done_store = req_active & dcache_resp & ex_mem_is_store;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_loads        <= '0;
      perf_stores       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (done_load && (perf_loads != '1))
        perf_loads <= perf_loads + CNT_WIDTH'(1);
      if (done_store && (perf_stores != '1))
        perf_stores <= perf_stores + CNT_WIDTH'(1);
      if (dmem_stall && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
